// File: rtl/sub_bytes_seq.sv
// Multi-cycle AES SubBytes engine with optional AddRoundKey, LANES bytes per cycle.
// Define SB_INV_EN to compile in the inverse S-box for the decryption path.
module sub_bytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data,
  input  logic [127:0] key,
  input  logic         key_en,
  input  logic         inv,
  output logic [127:0] sb_out,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int unsigned N     = 16 / LANES;
  localparam int unsigned CW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CHUNK = 8 * LANES;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [127:0]        r_src, r_res, r_sb_out;
  logic [6:0]          w_hi;
  logic                w_last;
  logic [CHUNK-1:0]    w_chunk_in, w_chunk_out;
  logic [127:0]        w_res_next;

  // GF(2^8) arithmetic; the S-box is derived from the field inverse plus the affine map.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1, with 0 mapping to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] s, r;
    s = a;
    r = 8'h01;
    for (int unsigned i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

`ifdef SB_INV_EN
  logic r_inv;

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction
`else
  logic w_unused_inv;
  assign w_unused_inv = inv;
`endif

  assign w_hi   = 7'(127 - CHUNK * 32'(r_cnt));
  assign w_last = (r_cnt == CW'(N - 1));

  always_comb begin
    w_chunk_in  = r_src[w_hi -: CHUNK];
    w_chunk_out = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
`ifdef SB_INV_EN
      w_chunk_out[CHUNK-1-8*l -: 8] = r_inv ? sbox_inv(w_chunk_in[CHUNK-1-8*l -: 8])
                                            : sbox_fwd(w_chunk_in[CHUNK-1-8*l -: 8]);
`else
      w_chunk_out[CHUNK-1-8*l -: 8] = sbox_fwd(w_chunk_in[CHUNK-1-8*l -: 8]);
`endif
    end
    w_res_next = r_res;
    w_res_next[w_hi -: CHUNK] = w_chunk_out;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_BUSY;
      S_BUSY:  if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_src    <= '0;
      r_res    <= '0;
      r_sb_out <= '0;
`ifdef SB_INV_EN
      r_inv    <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_src <= key_en ? (data ^ key) : data;
          r_cnt <= '0;
`ifdef SB_INV_EN
          r_inv <= inv;
`endif
        end
        S_BUSY: begin
          r_res <= w_res_next;
          r_cnt <= r_cnt + 1'b1;
          // Publish the merged result so sb_out only ever changes as a whole block
          if (w_last) r_sb_out <= w_res_next;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sb_out    = r_sb_out;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq: table-driven FIPS-197 model, directed vectors and random blocks.
module tb_sub_bytes_seq;

  localparam int unsigned LANES = 4;
  localparam int unsigned N     = 16 / LANES;

`ifdef SB_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk = 1'b0;
  logic         n_rst, in_valid, in_ready, key_en, inv, out_valid, out_ready;
  logic [127:0] data, key, sb_out;

  sub_bytes_seq #(.LANES(LANES)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .key(key), .key_en(key_en), .inv(inv),
    .sb_out(sb_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] exp;
    int unsigned  acc;
  } exp_t;

  logic [7:0]   sbox [256];
  logic [7:0]   isbox [256];
  exp_t         q[$];
  int unsigned  n_checks = 0, n_fail = 0, n_acc = 0, cyc = 0;
  bit           dir_use = 1'b0, prev_ov = 1'b0, hs_pending = 1'b0;
  logic [127:0] dir_exp = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic [127:0] k,
                                           input logic ke, input logic iv);
    logic [127:0] src, res;
    src = ke ? (d ^ k) : d;
    res = '0;
    for (int i = 0; i < 16; i++)
      res[127-8*i -: 8] = (INV_EN && iv) ? isbox[src[127-8*i -: 8]] : sbox[src[127-8*i -: 8]];
    return res;
  endfunction

  // Accept observer: expected result is queued at the accept edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    if (!n_rst) q.delete();
    else if (in_valid && in_ready) begin
      n_acc++;
      e.exp = dir_use ? dir_exp : ref_sub(data, key, key_en, inv);
      e.acc = cyc;
      q.push_back(e);
    end
  end

  // Output monitor, sampled just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (hs_pending) begin
      chk("in_ready_after_handshake", 128'(in_ready), 128'd1);
      hs_pending = 1'b0;
    end
    if (n_rst && out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", 128'(out_valid), 128'd0);
      else begin
        if (!prev_ov) begin
          chk("latency", 128'(cyc - q[0].acc), 128'(N));
          chk("in_ready_in_done", 128'(in_ready), 128'd0);
        end
        chk("sb_out", sb_out, q[0].exp);
        if (out_ready) begin
          void'(q.pop_front());
          hs_pending = 1'b1;
        end
      end
    end
    prev_ov = n_rst && out_valid;
  end

  task automatic send(input logic [127:0] d, input logic [127:0] k, input logic ke, input logic iv);
    int unsigned prev;
    bit ok;
    @(negedge clk);
    data = d; key = k; key_en = ke; inv = iv; in_valid = 1'b1;
    prev = n_acc;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (n_acc != prev);
    end
    if (!ok) chk("accept_timeout", 128'd0, 128'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit rnd_bp);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(negedge clk);
      ok = (q.size() == 0) && in_ready;
      if (rnd_bp) out_ready = 1'($urandom_range(0, 1));
    end
    if (!ok) chk("drain_timeout", 128'd0, 128'd1);
    out_ready = 1'b1;
  endtask

  task automatic run_dir(input logic [127:0] d, input logic [127:0] k, input logic ke,
                         input logic iv, input logic [127:0] e);
    dir_exp = e;
    dir_use = 1'b1;
    send(d, k, ke, iv);
    dir_use = 1'b0;
    wait_drain(1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] row;
    bit ok;
    for (int r = 0; r < 16; r++) begin
      row = SBOX_ROWS[r];
      for (int c = 0; c < 16; c++) sbox[r*16+c] = row[127-8*c -: 8];
    end
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);

    in_valid = 1'b0; data = '0; key = '0; key_en = 1'b0; inv = 1'b0;
    out_ready = 1'b1; n_rst = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_sb_out", sb_out, '0);
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    n_rst = 1'b1;

    run_dir('1, '0, 1'b0, 1'b0, {16{8'h16}});
    run_dir(128'h00112233445566778899aabbccddeeff, '0, 1'b0, 1'b0,
            128'h638293c31bfc33f5c4eeacea4bc12816);
    run_dir('1, '1, 1'b1, 1'b0, {16{8'h63}});
    run_dir('0, '1, 1'b0, 1'b0, {16{8'h63}});
`ifdef SB_INV_EN
    run_dir({16{8'h63}}, '0, 1'b0, 1'b1, '0);
    run_dir({16{8'h16}}, '0, 1'b0, 1'b1, '1);
    run_dir('0, '0, 1'b0, 1'b1, {16{8'h52}});
`else
    run_dir('0, '0, 1'b0, 1'b1, {16{8'h63}});
    run_dir({16{8'h63}}, '0, 1'b0, 1'b1, {16{8'hfb}});
`endif

    // Backpressure: DONE must hold while new requests are ignored.
    out_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, '0, 1'b0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
    if (!ok) chk("bp_out_valid_timeout", 128'd0, 128'd1);
    begin
      int unsigned acc0;
      acc0 = n_acc;
      for (int i = 0; i < 5; i++) begin
        in_valid = 1'(i % 2);
        data = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        chk("bp_out_valid", 128'(out_valid), 128'd1);
        chk("bp_in_ready", 128'(in_ready), 128'd0);
      end
      in_valid = 1'b0;
      chk("bp_no_accept", 128'(n_acc), 128'(acc0));
    end
    out_ready = 1'b1;
    wait_drain(1'b0);

    // Reset pulse on the second BUSY cycle discards the block.
    send({$urandom, $urandom, $urandom, $urandom}, '0, 1'b0, 1'b0);
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_sb_out", sb_out, '0);
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    run_dir('0, '0, 1'b0, 1'b0, {16{8'h63}});

    for (int b = 0; b < 30; b++) begin
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_drain(1'b1);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_bytes_seq.md
# sub_bytes_seq

Parametrised, multi-cycle AES SubBytes engine that replaces the single-shot combinational S-box stage in the encryption datapath. It accepts one 128-bit state word through a valid/ready handshake and optionally XORs it with a round key first (AddRoundKey). It then substitutes LANES bytes per clock and presents the 128-bit result through a second valid/ready handshake. LANES trades area for latency; a compile-time option adds the inverse S-box for the decryption path.

## Interface
- LANES, 4, S-box instances / bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  system clock, rising edge.
- n_rst  in  1  synchronous active-low reset.
- in_valid  in  1  data/key/key_en/inv valid.
- in_ready  out  1  engine can accept; high only in IDLE.
- data  in  128  input state; byte i = data[127-8i -: 8], byte 0 is MSB.
- key  in  128  round key, same byte order.
- key_en  in  1  1: substitute data^key; 0: substitute data.
- inv  in  1  1: inverse S-box (only with SB_INV_EN).
- sb_out  out  128  substituted state, same byte order.
- out_valid  out  1  sb_out holds a complete result.
- out_ready  in  1  downstream accepts sb_out.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset to IDLE with cnt=0, sb_out=0, out_valid=0. in_ready is 1 after reset.
- IDLE: in_ready=1. On in_valid&&in_ready, the engine latches src = key_en ? data^key : data and latches inv. It clears cnt and goes to BUSY. Inputs are not sampled again until the next IDLE.
- BUSY: each cycle substitutes bytes cnt*LANES .. cnt*LANES+LANES-1 of src into the same positions of the result register, then increments cnt. When cnt == 16/LANES-1, the last chunk is written and the next state is DONE.
- DONE: out_valid=1 and sb_out is stable. On out_ready, the next state is IDLE and out_valid drops.
- No same-cycle turnaround: in_valid is ignored in DONE even when out_ready is high.
- sb_out is updated only as a whole. Partial results stay in an internal register. sb_out keeps the last result after handshake and until the next DONE.
- Forward S-box per FIPS-197. Without SB_INV_EN, inv is ignored.
- Reset asserted in any state returns the FSM to IDLE and clears out_valid, sb_out and cnt on that edge. Any in-flight block is discarded.
- in_valid held high in BUSY/DONE has no effect.

## Timing
- The accept edge is edge 0. BUSY lasts N = 16/LANES cycles. out_valid rises after edge N: 16 cycles for LANES=1, 4 for LANES=4, 1 for LANES=16.
- in_ready rises on the cycle after the output handshake edge. Maximum throughput is one block per N+2 cycles.
- out_ready held low holds DONE indefinitely with no change on sb_out.
- The S-box lookup is combinational within the BUSY cycle. There is no additional pipeline register.

## Configuration
- SB_INV_EN defined: inverse S-box tables are compiled in, LANES copies. The inv value latched at accept selects the inverse table for every byte of that block.
- SB_INV_EN undefined: only forward tables exist. The inv port remains but is unconnected internally, and results are always forward.

## Test plan
- LANES=4, key_en=0, data='1, out_ready=1 -> out_valid exactly 4 cycles after accept, sb_out=16 repeated (all bytes 8'h16); in_ready high the next cycle.
- LANES=4, key_en=0, data=00112233445566778899aabbccddeeff -> sb_out=638293c31bfc33f5c4eeacea4bc12816. Repeat with LANES=1 (16-cycle latency) and LANES=16 (1-cycle latency): same value.
- key_en=1, data='1, key='1 -> sb_out=all 8'h63. key_en=0, data='0, key='1 -> sb_out=all 8'h63 (key ignored).
- SB_INV_EN defined, inv=1, data=all 8'h63 -> sb_out='0. inv=1, data=all 8'h16 -> sb_out='1. Without macro, inv=1, data='0 -> all 8'h63.
- Backpressure: out_ready low 5 cycles after out_valid, with in_valid pulsed meanwhile -> sb_out and out_valid stable, in_ready=0, second block not accepted.
- n_rst low for one edge at the 2nd BUSY cycle (LANES=4) -> out_valid=0 and sb_out=0 after that edge, in_ready=1. A fresh block then completes normally in 4 cycles.
